mask_serializer: RTL and testbench

- Accepts a WIDTH-bit request mask (free-list release, ROB commit, or wakeup vector) and emits the set bits one per cycle, lowest index first, as a one-hot vector and a binary index.
- Inverse of the prefix-OR mask generation used elsewhere in the core. It converts a thermometer-extended mask back to a one-hot, then clears that bit from a residual register.
- Sits between any mask-producing unit and a single-port consumer, e.g. the free-list write port or the PRF tag broadcast.

---
 rtl/mask_serializer.sv | 100 ++++++++++
 tb/tb_mask_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mask_serializer.sv
// Serializes a request mask into one set bit per cycle, lowest index first,
// presented as a one-hot vector plus its binary index.
module mask_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_aL,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_onehot,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] ext_c;
   logic [WIDTH-1:0] onehot_c;
   logic [IDX_W-1:0] idx_c;
   logic             accept_c;
   logic             pop_c;

   // Thermometer-extend the residual; the one-hot is the first rising step.
   always_comb begin
      logic seen;
      seen     = 1'b0;
      ext_c    = '0;
      onehot_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         onehot_c[i] = rem_q[i] & ~seen;
         seen        = seen | rem_q[i];
         ext_c[i]    = seen;
      end
   end

   always_comb begin
      idx_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot_c[i]) begin
            idx_c = idx_c | IDX_W'(i);
         end
      end
   end

   // Outputs follow the residual directly so a stalled output stays put.
   always_comb begin
      out_valid  = (state_q == DRAIN);
      busy       = (state_q == DRAIN);
      out_onehot = onehot_c;
      out_idx    = idx_c;
      out_last   = out_valid & ((rem_q & ~onehot_c) == '0);
      in_ready   = (state_q == IDLE) | (out_valid & out_ready & out_last);
   end

   assign pop_c    = out_valid & out_ready;
   assign accept_c = in_valid & in_ready & ~flush;

   // Flush wins over both accept and pop; an accepted empty mask stays IDLE.
   always_comb begin
      rem_d   = rem_q;
      state_d = state_q;
      if (flush) begin
         rem_d   = '0;
         state_d = IDLE;
      end else begin
         if (pop_c) begin
            rem_d = rem_q & ~onehot_c;
         end
         if (accept_c) begin
            rem_d = in_mask;
         end
         state_d = (rem_d != '0) ? DRAIN : IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   logic unused_ext;
   assign unused_ext = ^ext_c;

endmodule

// File: tb/tb_mask_serializer.sv
// Scoreboarded bench for mask_serializer: directed scenarios then random masks,
// checked against a per-bit expansion of each accepted mask.
module tb_mask_serializer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned IDX_W = 3;

   logic             clk;
   logic             rst_aL;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_mask;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_onehot;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             busy;

   typedef struct {
      int unsigned idx;
      int unsigned onehot;
      int unsigned last;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   mask_serializer #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .rst_aL     (rst_aL),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mask    (in_mask),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: every set bit in ascending order, last flag on the highest one.
   task automatic push_mask(input logic [WIDTH-1:0] m);
      int hi;
      hi = -1;
      for (int i = 0; i < int'(WIDTH); i++) if (m[i]) hi = i;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (m[i]) begin
            exp_t e;
            e.idx    = i;
            e.onehot = 1 << i;
            e.last   = (i == hi) ? 1 : 0;
            q.push_back(e);
         end
      end
   endtask

   // Monitor: checks handshake signals every cycle and pops on each consumed output.
   always @(negedge clk) begin
      if (rst_aL) begin
         int unsigned ev;
         int unsigned er;
         ev = (q.size() != 0) ? 1 : 0;
         er = (q.size() == 0 || (out_ready && q.size() == 1)) ? 1 : 0;
         chk("out_valid", 32'(out_valid), ev);
         chk("busy", 32'(busy), ev);
         chk("in_ready", 32'(in_ready), er);
         if (q.size() != 0) begin
            chk("out_idx", 32'(out_idx), q[0].idx);
            chk("out_onehot", 32'(out_onehot), q[0].onehot);
            chk("out_last", 32'(out_last), q[0].last);
            if (out_ready && !flush) void'(q.pop_front());
         end else begin
            chk("idle_idx", 32'(out_idx), 0);
            chk("idle_onehot", 32'(out_onehot), 0);
            chk("idle_last", 32'(out_last), 0);
         end
      end
   end

   // One clock of stimulus, entered and left at posedge+1.
   task automatic cycle(input logic v, input logic [WIDTH-1:0] m, input logic r, input logic f);
      logic acc;
      in_valid  = v;
      in_mask   = m;
      out_ready = r;
      flush     = f;
      @(negedge clk);
      acc = v && in_ready && !f;
      @(posedge clk);
      #1;
      if (f) q.delete();
      if (acc) push_mask(m);
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, r, 1'b0);
   endtask

   initial begin
      rst_aL    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_mask   = '0;
      out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_idx", 32'(out_idx), 0);
      chk("rst_out_onehot", 32'(out_onehot), 0);
      chk("rst_out_last", 32'(out_last), 0);
      #10;
      rst_aL = 1'b1;
      @(posedge clk);
      #1;

      // Sparse mask: indices 2, 5, 7
      cycle(1'b1, 8'hA4, 1'b1, 1'b0);
      idle(4, 1'b1);

      // All ones, then a new mask offered exactly in the last-pop cycle
      cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      idle(7, 1'b1);
      cycle(1'b1, 8'h01, 1'b1, 1'b0);
      idle(2, 1'b1);

      // Stall on the first output
      cycle(1'b1, 8'h12, 1'b1, 1'b0);
      idle(3, 1'b0);
      idle(3, 1'b1);

      // Empty mask, then top bit alone
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
      idle(2, 1'b1);
      cycle(1'b1, 8'h80, 1'b1, 1'b0);
      idle(2, 1'b1);

      // Flush mid-drain with a mask offered, and flush while idle with a mask offered
      cycle(1'b1, 8'hF0, 1'b1, 1'b0);
      idle(1, 1'b1);
      cycle(1'b1, 8'h03, 1'b1, 1'b1);
      idle(1, 1'b1);
      cycle(1'b1, 8'h03, 1'b1, 1'b1);
      idle(2, 1'b1);

      // Asynchronous reset during a drain
      cycle(1'b1, 8'hAA, 1'b1, 1'b0);
      idle(1, 1'b1);
      in_valid = 1'b0;
      #2;
      rst_aL = 1'b0;
      q.delete();
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 0);
      chk("async_rst_busy", 32'(busy), 0);
      @(negedge clk);
      #2;
      rst_aL = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);
      chk("post_rst_out_valid", 32'(out_valid), 0);
      @(posedge clk);
      #1;

      // Random masks with random backpressure and occasional flush
      for (int n = 0; n < 400; n++) begin
         logic [WIDTH-1:0] m;
         case ($urandom_range(0, 3))
            0:       m = '0;
            1:       m = 8'(1 << $urandom_range(0, WIDTH - 1));
            default: m = 8'($urandom);
         endcase
         cycle(1'($urandom_range(0, 1)), m, ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 40) == 0));
      end

      // Drain whatever remains, bounded
      for (int n = 0; n < 40 && q.size() != 0; n++) idle(1, 1'b1);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", q.size());
      end
      idle(2, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
